// File: rtl/wbu_pkg.sv
// Shared register-file and write-back constants for the write-back unit.
package wbu_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int AW             = REG_ADDR_WIDTH;
    localparam int DW             = REG_DATA_WIDTH;
    localparam int REG_COUNT      = 1 << REG_ADDR_WIDTH;
    localparam int LSU_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU,
        SRC_MDU
    } wb_src_e;
endpackage

// File: rtl/wbu_fifo.sv
// Small LSU result buffer (address + data), registered head, no fall-through.
module wbu_fifo
    import wbu_pkg::*;
#(
    parameter int AW = wbu_pkg::AW,
    parameter int DW = wbu_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o
);
    localparam int PW = $clog2(LSU_FIFO_DEPTH);

    logic [AW+DW-1:0] mem_q [LSU_FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [PW:0]      cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
        end
    end

    assign full_o  = (cnt_q == (PW+1)'(LSU_FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign {head_addr_o, head_data_o} = mem_q[rd_ptr_q];
endmodule

// File: rtl/wbu.sv
// Write-back unit: fixed-priority ALU > LSU > MDU arbitration, registered RF write, pending scoreboard.
// Define WBU_LSU_FIFO_EN to buffer load results in a 2-entry FIFO (wbu_fifo).
module wbu
    import wbu_pkg::*;
#(
    parameter int AW = wbu_pkg::AW,
    parameter int DW = wbu_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we_i,
    input  logic [AW-1:0]     alu_waddr_i,
    input  logic [DW-1:0]     alu_wdata_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [AW-1:0]     lsu_waddr_i,
    input  logic [DW-1:0]     lsu_wdata_i,
    input  logic              mdu_valid_i,
    output logic              mdu_ready_o,
    input  logic [AW-1:0]     mdu_waddr_i,
    input  logic [DW-1:0]     mdu_wdata_i,
    input  logic              issue_i,
    input  logic [AW-1:0]     issue_rd_i,
    output logic [2**AW-1:0]  pend_o,
    output logic              we_o,
    output logic [AW-1:0]     waddr_o,
    output logic [DW-1:0]     wdata_o
);
    localparam int NREG = 2**AW;

    wb_src_e         src;
    logic            lsu_avail;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_data;

    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] pend_q, pend_d;

`ifdef WBU_LSU_FIFO_EN
    logic fifo_full, fifo_empty, fifo_pop;

    assign lsu_ready_o = !rst && !fifo_full;
    assign mdu_ready_o = !rst && !alu_we_i && fifo_empty;
    assign fifo_pop    = !alu_we_i && !fifo_empty;
    assign lsu_avail   = !fifo_empty;

    wbu_fifo #(.AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (lsu_valid_i && lsu_ready_o),
        .push_addr_i (lsu_waddr_i),
        .push_data_i (lsu_wdata_i),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_addr_o (lsu_addr),
        .head_data_o (lsu_data)
    );
`else
    assign lsu_ready_o = !rst && !alu_we_i;
    assign mdu_ready_o = !rst && !alu_we_i && !lsu_valid_i;
    assign lsu_avail   = lsu_valid_i;
    assign lsu_addr    = lsu_waddr_i;
    assign lsu_data    = lsu_wdata_i;
`endif

    always_comb begin
        src = SRC_NONE;
        if (alu_we_i)         src = SRC_ALU;
        else if (lsu_avail)   src = SRC_LSU;
        else if (mdu_valid_i) src = SRC_MDU;
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        case (src)
            SRC_ALU: begin waddr_d = alu_waddr_i; wdata_d = alu_wdata_i; end
            SRC_LSU: begin waddr_d = lsu_addr;    wdata_d = lsu_data;    end
            SRC_MDU: begin waddr_d = mdu_waddr_i; wdata_d = mdu_wdata_i; end
            default: ;
        endcase
        // x0 writes complete the handshake but never reach the register file
        if (src != SRC_NONE) we_d = (waddr_d != '0);
        if (src == SRC_LSU || src == SRC_MDU) pend_d[waddr_d] = 1'b0;
        // set after clear so a same-cycle reissue keeps the register pending
        if (issue_i && issue_rd_i != '0) pend_d[issue_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign pend_o  = pend_q;
endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 Parameter AW, default 5, register address width (32 architectural registers).
REQ-002 Parameter DW, default 32, register data width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high; clock clk.
REQ-005 alu_we_i  input  1  ALU result valid; this path has no backpressure.
REQ-006 alu_waddr_i  input  AW  ALU destination register.
REQ-007 alu_wdata_i  input  DW  ALU result.
REQ-008 lsu_valid_i  input  1  load result valid.
REQ-009 lsu_ready_o  output  1  load result accepted this cycle when high together with lsu_valid_i.
REQ-010 lsu_waddr_i  input  AW  load destination register.
REQ-011 lsu_wdata_i  input  DW  load data.
REQ-012 mdu_valid_i  input  1  mul/div result valid.
REQ-013 mdu_ready_o  output  1  mul/div result accepted this cycle when high together with mdu_valid_i.
REQ-014 mdu_waddr_i  input  AW  mul/div destination register.
REQ-015 mdu_wdata_i  input  DW  mul/div result.
REQ-016 issue_i  input  1  ID issued a long-latency (load or mul/div) instruction this cycle.
REQ-017 issue_rd_i  input  AW  destination register of the issued instruction.
REQ-018 pend_o  output  2**AW  scoreboard bitmap; bit n high means register n has an outstanding long-latency write.
REQ-019 we_o  output  1  register-file write enable.
REQ-020 waddr_o  output  AW  register-file write address.
REQ-021 wdata_o  output  DW  register-file write data.

Function
REQ-022 Output registers: we_o, waddr_o and wdata_o SHALL be registered, with exactly 1 cycle from acceptance to the write appearing on the outputs.
REQ-023 Arbitration SHALL be fixed priority, ALU > LSU > MDU; at most one source is granted per cycle.
REQ-024 Without the FIFO, lsu_ready_o SHALL equal !alu_we_i, and mdu_ready_o SHALL equal !alu_we_i && !lsu_valid_i.
REQ-025 Writes to address 0 SHALL be accepted (handshake completes) but SHALL produce we_o=0.
REQ-026 When nothing is granted in a cycle, we_o SHALL be 0 in the next cycle; waddr_o and wdata_o SHALL hold their previous values.
REQ-027 Scoreboard set: issue_i with issue_rd_i != 0 SHALL set pend_o[issue_rd_i] at the next edge.
REQ-028 Scoreboard clear: an accepted LSU or MDU write SHALL clear pend_o[rd] at the same edge as the write is registered; ALU writes SHALL NOT clear pending bits.
REQ-029 Simultaneous set and clear of the same register SHALL leave the bit set (the new issue wins).
REQ-030 pend_o[0] SHALL always read 0.

Reset
REQ-031 While rst=1, at each edge: we_o=0, waddr_o=0, wdata_o=0, pend_o=0, FIFO emptied; lsu_ready_o and mdu_ready_o SHALL be 0 combinationally.
REQ-032 Reset asserted mid-operation SHALL drop buffered and in-flight results without any write.

Configuration
REQ-033 Macro WBU_LSU_FIFO_EN defined: a 2-entry LSU FIFO SHALL be present; lsu_ready_o = !full; the FIFO head is granted when !alu_we_i; mdu_ready_o = !alu_we_i && FIFO empty.
REQ-034 FIFO behaviour: a push while full is impossible by the handshake; a simultaneous push and pop SHALL keep occupancy unchanged; a push into an empty FIFO SHALL NOT be granted before the following cycle (no fall-through).
REQ-035 Macro WBU_LSU_FIFO_EN undefined: no FIFO; REQ-024 applies.

Structure
REQ-036 AW, DW, the register count and the FIFO depth constant (2) SHALL be placed in the shared defines package alongside REG_ADDR_WIDTH and REG_DATA_WIDTH.
REQ-037 The FIFO SHALL be a sub-module named wbu_fifo; the scoreboard stays inline.

Verification
REQ-038 ALU x5=0x11 and LSU x6=0x22 valid in the same cycle, no FIFO -> cycle+1 write x5=0x11, lsu_ready_o=0; LSU held; cycle+2 write x6=0x22.
REQ-039 issue_i with rd=7; 3 cycles later MDU x7=0xABCD accepted -> pend_o[7]=1 until the write edge, then 0; we_o=1, waddr_o=7.
REQ-040 LSU write x9 accepted in the same cycle as issue_i rd=9 -> pend_o[9] remains 1.
REQ-041 MDU write to x0 with data 0xFFFF -> mdu_ready_o=1, we_o stays 0, pend_o unchanged.
REQ-042 FIFO enabled: alu_we_i=1 for 4 cycles while LSU offers 3 loads -> 2 accepted, then lsu_ready_o=0; after the ALU stops, loads drain in order on consecutive cycles; MDU is blocked until the FIFO is empty.
REQ-043 rst pulsed with 2 FIFO entries and pend_o=0x0000_0280 -> next cycle pend_o=0, we_o=0, no drained writes.
